// File: rtl/io_access_arbiter_pkg.sv
// Shared types and constants for the KabIO register-port arbiter.
// The round-robin distance helper is also meant for the EIC priority logic.
package io_arb_pkg;

  localparam int MAX_REQ        = 4;
  localparam int MAX_RD_LATENCY = 3;
  localparam int IDX_W          = $clog2(MAX_REQ);
  localparam int CNT_W          = $clog2(MAX_RD_LATENCY + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT_RD = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic        Write;
    logic [29:0] Address;
    logic [31:0] WrData;
  } io_cmd_t;

  // Search distance of requester j when the last winner was 'last'; 0 = next in line.
  function automatic int rr_dist(input int j, input int last, input int n);
    int d;
    d = j + n - 1 - last;
    if (d >= n) d = d - n;
    return d;
  endfunction

endpackage

// File: rtl/io_access_arbiter_if.sv
// Requester-side and KabIO-side signals of the arbiter, bundled as one interface.
// The arbiter uses the slave view; requesters and KabIO together form the master view.
interface io_access_arbiter_if #(
  parameter int NUM_REQ = 2
);

  logic [NUM_REQ-1:0]       Req_Valid;
  logic [NUM_REQ-1:0]       Req_Write;
  logic [NUM_REQ-1:0][29:0] Req_Address;
  logic [NUM_REQ-1:0][31:0] Req_WrData;
  logic [NUM_REQ-1:0]       Req_Grant;
  logic [NUM_REQ-1:0]       Req_RdValid;
  logic [31:0]              Req_RdData;
  logic [29:0]              Sys_Address;
  logic [31:0]              Sys_WrData;
  logic                     Sys_WrEn;
  logic                     Sys_RdEn;
  logic [31:0]              Sys_RdData;
  logic                     Busy;

  modport slave (
    input  Req_Valid, Req_Write, Req_Address, Req_WrData, Sys_RdData,
    output Req_Grant, Req_RdValid, Req_RdData,
    output Sys_Address, Sys_WrData, Sys_WrEn, Sys_RdEn, Busy
  );

  modport master (
    output Req_Valid, Req_Write, Req_Address, Req_WrData, Sys_RdData,
    input  Req_Grant, Req_RdValid, Req_RdData,
    input  Sys_Address, Sys_WrData, Sys_WrEn, Sys_RdEn, Busy
  );

endinterface

// File: rtl/io_access_arbiter_rr_pick.sv
// Combinational round-robin selector: the first requester after i_last wins.
module rr_pick
  import io_arb_pkg::*;
#(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  int w_best;
  int w_dist;

  always_comb begin
    o_idx  = '0;
    o_any  = 1'b0;
    w_best = NUM_REQ;
    w_dist = 0;
    for (int j = 0; j < NUM_REQ; j++) begin
      w_dist = rr_dist(j, int'(i_last), NUM_REQ);
      if (i_req[j] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_idx  = IDX_W'(j);
        o_any  = 1'b1;
      end
    end
  end

  always_comb begin
    o_grant = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      o_grant[j] = o_any && (o_idx == IDX_W'(j));
    end
  end

endmodule

// File: rtl/io_access_arbiter.sv
// Round-robin arbiter sharing the single KabIO register port between NUM_REQ requesters.
// One access outstanding at a time: grant, one-cycle strobe, then optional read wait.
module io_access_arbiter
  import io_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int RD_LATENCY = 1
) (
  input  logic                Sys_Clock,
  input  logic                Sys_Reset,
  io_access_arbiter_if.slave  bus
);

  arb_state_t           r_state;
  arb_state_t           w_state_nxt;
  io_cmd_t              r_cmd;
  io_cmd_t              w_cmd_sel;
  logic [NUM_REQ-1:0]   r_cmd_oh;
  logic [NUM_REQ-1:0]   r_rdvalid_oh;
  logic [NUM_REQ-1:0]   w_pick_oh;
  logic [IDX_W-1:0]     r_last;
  logic [IDX_W-1:0]     w_pick_idx;
  logic                 w_pick_any;
  logic [CNT_W-1:0]     r_cnt;
  logic [31:0]          r_rddata;
  logic                 w_accept;
  logic                 w_sample;

  rr_pick #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_pick (
    .i_req   (bus.Req_Valid),
    .i_last  (r_last),
    .o_grant (w_pick_oh),
    .o_idx   (w_pick_idx),
    .o_any   (w_pick_any)
  );

  always_comb begin
    w_cmd_sel = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_pick_oh[j]) begin
        w_cmd_sel.Write   = bus.Req_Write[j];
        w_cmd_sel.Address = bus.Req_Address[j];
        w_cmd_sel.WrData  = bus.Req_WrData[j];
      end
    end
  end

  // WAIT_RD spans the read latency plus the RdValid cycle, so the port frees at T+3+RD_LATENCY.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sample    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_pick_any) begin
          w_accept    = 1'b1;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        w_state_nxt = r_cmd.Write ? IDLE : WAIT_RD;
      end
      WAIT_RD: begin
        if (r_cnt == CNT_W'(1)) w_sample = 1'b1;
        if (r_cnt == '0)        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge Sys_Clock or posedge Sys_Reset) begin
    if (Sys_Reset) begin
      r_state      <= IDLE;
      r_last       <= IDX_W'(NUM_REQ - 1);
      r_cmd        <= '0;
      r_cmd_oh     <= '0;
      r_cnt        <= '0;
      r_rdvalid_oh <= '0;
      r_rddata     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_rdvalid_oh <= w_sample ? r_cmd_oh : '0;
      if (w_accept) begin
        r_cmd    <= w_cmd_sel;
        r_cmd_oh <= w_pick_oh;
        r_last   <= w_pick_idx;
      end
      if (r_state == ISSUE) begin
        r_cnt <= CNT_W'(RD_LATENCY);
      end else if ((r_state == WAIT_RD) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (w_sample) r_rddata <= bus.Sys_RdData;
    end
  end

  // Address/data come straight from the command register, so they hold between accesses.
  assign bus.Req_Grant   = (r_state == IDLE) ? w_pick_oh : '0;
  assign bus.Sys_WrEn    = (r_state == ISSUE) &&  r_cmd.Write;
  assign bus.Sys_RdEn    = (r_state == ISSUE) && !r_cmd.Write;
  assign bus.Sys_Address = r_cmd.Address;
  assign bus.Sys_WrData  = r_cmd.WrData;
  assign bus.Req_RdValid = r_rdvalid_oh;
  assign bus.Req_RdData  = r_rddata;
  assign bus.Busy        = (r_state != IDLE);

endmodule

// File: tb/tb_io_access_arbiter.sv
// Directed bench for io_access_arbiter: a 2-requester/latency-1 and a 4-requester/latency-3 instance.
module tb_io_access_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  io_access_arbiter_if #(.NUM_REQ(2)) bus_a ();
  io_access_arbiter_if #(.NUM_REQ(4)) bus_b ();

  io_access_arbiter #(.NUM_REQ(2), .RD_LATENCY(1)) dut_a (
    .Sys_Clock (clk),
    .Sys_Reset (rst),
    .bus       (bus_a)
  );

  io_access_arbiter #(.NUM_REQ(4), .RD_LATENCY(3)) dut_b (
    .Sys_Clock (clk),
    .Sys_Reset (rst),
    .bus       (bus_b)
  );

  // KabIO models: read data is present only RD_LATENCY cycles after the strobe, poison otherwise.
  logic [31:0] kab_a_word = 32'h1234_5678;
  logic        kab_a_v    = 1'b0;
  logic [31:0] kab_a_d    = '0;
  logic        kb_v0 = 1'b0, kb_v1 = 1'b0, kb_v2 = 1'b0;
  logic [31:0] kb_d0 = '0, kb_d1 = '0, kb_d2 = '0;

  always @(posedge clk) begin
    kab_a_v <= bus_a.Sys_RdEn;
    kab_a_d <= kab_a_word;
    kb_v0   <= bus_b.Sys_RdEn;
    kb_d0   <= {2'b11, bus_b.Sys_Address};
    kb_v1   <= kb_v0;
    kb_d1   <= kb_d0;
    kb_v2   <= kb_v1;
    kb_d2   <= kb_d1;
  end

  assign bus_a.Sys_RdData = kab_a_v ? kab_a_d : 32'hBAD0_BAD0;
  assign bus_b.Sys_RdData = kb_v2   ? kb_d2   : 32'hBAD0_BAD0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_a.Req_Valid   = '0;
    bus_a.Req_Write   = '0;
    bus_a.Req_Address = '0;
    bus_a.Req_WrData  = '0;
    bus_b.Req_Valid   = '0;
    bus_b.Req_Write   = '0;
    bus_b.Req_Address = '0;
    bus_b.Req_WrData  = '0;

    // Reset state
    step();
    step();
    #1;
    chk("rst_grant",   bus_a.Req_Grant,   2'b00);
    chk("rst_wren",    bus_a.Sys_WrEn,    1'b0);
    chk("rst_rden",    bus_a.Sys_RdEn,    1'b0);
    chk("rst_busy",    bus_a.Busy,        1'b0);
    chk("rst_rdvalid", bus_a.Req_RdValid, 2'b00);
    chk("rst_rddata",  bus_a.Req_RdData,  32'h0);
    chk("rst_addr",    bus_a.Sys_Address, 30'h0);
    chk("rst_b_busy",  bus_b.Busy,        1'b0);
    rst = 1'b0;

    // Single write from req0
    step();
    bus_a.Req_Valid      = 2'b01;
    bus_a.Req_Write      = 2'b01;
    bus_a.Req_Address[0] = 30'h000_0010;
    bus_a.Req_WrData[0]  = 32'hDEAD_BEEF;
    #1;
    chk("wr_grant_T",  bus_a.Req_Grant, 2'b01);
    chk("wr_wren_T",   bus_a.Sys_WrEn,  1'b0);
    chk("wr_busy_T",   bus_a.Busy,      1'b0);
    step();
    bus_a.Req_Valid = 2'b00;
    #1;
    chk("wr_wren_T1",  bus_a.Sys_WrEn,    1'b1);
    chk("wr_rden_T1",  bus_a.Sys_RdEn,    1'b0);
    chk("wr_addr_T1",  bus_a.Sys_Address, 30'h000_0010);
    chk("wr_data_T1",  bus_a.Sys_WrData,  32'hDEAD_BEEF);
    chk("wr_busy_T1",  bus_a.Busy,        1'b1);
    chk("wr_grant_T1", bus_a.Req_Grant,   2'b00);
    step();
    #1;
    chk("wr_wren_T2",  bus_a.Sys_WrEn,    1'b0);
    chk("wr_rden_T2",  bus_a.Sys_RdEn,    1'b0);
    chk("wr_busy_T2",  bus_a.Busy,        1'b0);
    chk("wr_hold_T2",  bus_a.Sys_Address, 30'h000_0010);

    // Read from req1, latency 1
    step();
    bus_a.Req_Valid      = 2'b10;
    bus_a.Req_Write      = 2'b00;
    bus_a.Req_Address[1] = 30'h000_0020;
    #1;
    chk("rd_grant_T",   bus_a.Req_Grant, 2'b10);
    step();
    bus_a.Req_Valid = 2'b00;
    #1;
    chk("rd_rden_T1",   bus_a.Sys_RdEn,    1'b1);
    chk("rd_wren_T1",   bus_a.Sys_WrEn,    1'b0);
    chk("rd_addr_T1",   bus_a.Sys_Address, 30'h000_0020);
    step();
    #1;
    chk("rd_rden_T2",   bus_a.Sys_RdEn,    1'b0);
    chk("rd_vld_T2",    bus_a.Req_RdValid, 2'b00);
    chk("rd_busy_T2",   bus_a.Busy,        1'b1);
    step();
    #1;
    chk("rd_vld_T3",    bus_a.Req_RdValid, 2'b10);
    chk("rd_data_T3",   bus_a.Req_RdData,  32'h1234_5678);
    step();
    #1;
    chk("rd_vld_T4",    bus_a.Req_RdValid, 2'b00);
    chk("rd_busy_T4",   bus_a.Busy,        1'b0);
    chk("rd_hold_T4",   bus_a.Req_RdData,  32'h1234_5678);

    // Both requesters hold valid for 6 writes: strict alternation, 2 cycles apart
    step();
    bus_a.Req_Valid      = 2'b11;
    bus_a.Req_Write      = 2'b11;
    bus_a.Req_Address[0] = 30'h000_0100;
    bus_a.Req_Address[1] = 30'h000_0101;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("rr_grant_%0d", k), bus_a.Req_Grant, (k % 2 == 0) ? 2'b01 : 2'b10);
      step();
      if (k == 5) bus_a.Req_Valid = 2'b00;
      #1;
      chk($sformatf("rr_gap_%0d", k),  bus_a.Req_Grant,   2'b00);
      chk($sformatf("rr_wren_%0d", k), bus_a.Sys_WrEn,    1'b1);
      chk($sformatf("rr_addr_%0d", k), bus_a.Sys_Address, (k % 2 == 0) ? 30'h100 : 30'h101);
      step();
    end
    #1;
    chk("rr_done_grant", bus_a.Req_Grant, 2'b00);
    chk("rr_done_busy",  bus_a.Busy,      1'b0);

    // req0 requests then withdraws while req1 holds the port with a read
    bus_a.Req_Valid      = 2'b10;
    bus_a.Req_Write      = 2'b00;
    bus_a.Req_Address[1] = 30'h000_0030;
    #1;
    chk("wd_grant1",  bus_a.Req_Grant, 2'b10);
    step();
    bus_a.Req_Valid = 2'b01;
    #1;
    chk("wd_issue_grant", bus_a.Req_Grant, 2'b00);
    step();
    #1;
    chk("wd_wait_grant",  bus_a.Req_Grant, 2'b00);
    bus_a.Req_Valid = 2'b00;
    step();
    #1;
    chk("wd_rdvalid",     bus_a.Req_RdValid, 2'b10);
    chk("wd_rddata",      bus_a.Req_RdData,  32'h1234_5678);
    step();
    #1;
    chk("wd_idle_grant",  bus_a.Req_Grant, 2'b00);
    chk("wd_idle_busy",   bus_a.Busy,      1'b0);
    step();
    #1;
    chk("wd_still_idle",  bus_a.Busy,      1'b0);

    // Asynchronous reset while waiting for read data
    bus_a.Req_Valid      = 2'b10;
    bus_a.Req_Address[1] = 30'h000_0040;
    step();
    bus_a.Req_Valid = 2'b00;
    step();
    #1;
    chk("ar_busy_pre", bus_a.Busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("ar_wren",  bus_a.Sys_WrEn,    1'b0);
    chk("ar_rden",  bus_a.Sys_RdEn,    1'b0);
    chk("ar_busy",  bus_a.Busy,        1'b0);
    chk("ar_vld",   bus_a.Req_RdValid, 2'b00);
    step();
    rst = 1'b0;
    step();
    #1;
    chk("ar_novld1", bus_a.Req_RdValid, 2'b00);
    step();
    #1;
    chk("ar_novld2", bus_a.Req_RdValid, 2'b00);
    bus_a.Req_Valid = 2'b11;
    bus_a.Req_Write = 2'b11;
    #1;
    chk("ar_first_grant", bus_a.Req_Grant, 2'b01);
    step();
    bus_a.Req_Valid = 2'b00;
    step();

    // Four requesters, latency 3: back-to-back reads from req2 and req3
    bus_b.Req_Valid      = 4'b1100;
    bus_b.Req_Write      = 4'b0000;
    bus_b.Req_Address[2] = 30'h000_00AB;
    bus_b.Req_Address[3] = 30'h000_00CD;
    #1;
    chk("b_grant2_T", bus_b.Req_Grant, 4'b0100);
    step();
    bus_b.Req_Valid = 4'b1000;
    #1;
    chk("b_rden_T1",  bus_b.Sys_RdEn,    1'b1);
    chk("b_addr_T1",  bus_b.Sys_Address, 30'h000_00AB);
    for (int c = 2; c <= 4; c++) begin
      step();
      #1;
      chk($sformatf("b_novld_T%0d", c), bus_b.Req_RdValid, 4'b0000);
      chk($sformatf("b_nogr_T%0d", c),  bus_b.Req_Grant,   4'b0000);
    end
    step();
    #1;
    chk("b_vld2_T5",   bus_b.Req_RdValid, 4'b0100);
    chk("b_data2_T5",  bus_b.Req_RdData,  {2'b11, 30'h000_00AB});
    chk("b_nogr_T5",   bus_b.Req_Grant,   4'b0000);
    step();
    #1;
    chk("b_grant3_T6", bus_b.Req_Grant,   4'b1000);
    chk("b_novld_T6",  bus_b.Req_RdValid, 4'b0000);
    step();
    bus_b.Req_Valid = 4'b0000;
    #1;
    chk("b_rden_T7",   bus_b.Sys_RdEn,    1'b1);
    chk("b_addr_T7",   bus_b.Sys_Address, 30'h000_00CD);
    for (int c = 8; c <= 10; c++) begin
      step();
      #1;
      chk($sformatf("b_novld_T%0d", c), bus_b.Req_RdValid, 4'b0000);
    end
    step();
    #1;
    chk("b_vld3_T11",  bus_b.Req_RdValid, 4'b1000);
    chk("b_data3_T11", bus_b.Req_RdData,  {2'b11, 30'h000_00CD});
    step();
    #1;
    chk("b_idle_T12",  bus_b.Busy,        1'b0);
    chk("b_hold_T12",  bus_b.Req_RdData,  {2'b11, 30'h000_00CD});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
